// File: rtl/ece571f23_g5_aes_pkg.sv
// ---------------------------------------------------------------------------
// ece571f23_g5_aes_pkg
// Shared types, constants and GF(2^8) / AES round helpers for the g5 AES
// datapath. The S-box is built algebraically (multiplicative inverse in
// GF(2^8) followed by the affine transform) rather than from a 256-entry table.
// Block byte order: byte 0 in [127:120], column-major (byte 4c+r = row r,
// column c).
// ---------------------------------------------------------------------------
package ece571f23_g5_aes_pkg;

    typedef logic [127:0] aes_blk_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_e;

    localparam int NR_AES128 = 10;

    localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    // Inverse is b^254; exponent bits are walked MSB first.
    localparam logic [7:0] INV_EXP = 8'hFE;

    // Round constant for round r (1..10); 0 outside that range.
    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 1; i <= NR_AES128; i++) begin
            v = (r == i[3:0]) ? RCON[i] : v;
        end
        return v;
    endfunction

    // Multiply by x modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = p ^ (b[i] ? aa : 8'h00);
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse by square-and-multiply; maps 0 to 0 naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] b);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            r = INV_EXP[i] ? gf_mul(r, b) : r;
        end
        return r;
    endfunction

    // Forward S-box: inverse followed by the affine transform with 0x63.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] x;
        x = gf_inv(b);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic aes_blk_t sub_bytes(input aes_blk_t s);
        aes_blk_t o;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            o[127 - 8*k -: 8] = sbox(s[127 - 8*k -: 8]);
        end
        return o;
    endfunction

    // Row r rotates left by r columns.
    function automatic aes_blk_t shift_rows(input aes_blk_t s);
        aes_blk_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic aes_blk_t mix_columns(input aes_blk_t s);
        aes_blk_t o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                   xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

endpackage

// File: rtl/ece571f23_g5_aes_iter_ctrl_if.sv
// ---------------------------------------------------------------------------
// ece571f23_g5_aes_iter_ctrl_if
// Input and output valid/ready channels of the iterative AES sequencer.
//   in_valid/in_ready/plaintext/key : plaintext/key pair offered by producer
//   out_valid/out_ready/cipher      : ciphertext returned to consumer
// master = producer/consumer side, slave = the sequencer.
// ---------------------------------------------------------------------------
interface ece571f23_g5_aes_iter_ctrl_if;
    import ece571f23_g5_aes_pkg::*;

    logic     in_valid;
    logic     in_ready;
    aes_blk_t plaintext;
    aes_blk_t key;
    logic     out_valid;
    logic     out_ready;
    aes_blk_t cipher;

    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, cipher
    );

    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, cipher
    );

endinterface

// File: rtl/ece571f23_g5_aes_key_step.sv
// ---------------------------------------------------------------------------
// ece571f23_g5_aes_key_step
// One AES-128 key-expansion step, purely combinational.
//   kin  : previous round key (word 0 in [127:96])
//   rcon : round constant for the key being produced
//   kout : next round key
// ---------------------------------------------------------------------------
module ece571f23_g5_aes_key_step
    import ece571f23_g5_aes_pkg::*;
(
    input  aes_blk_t   kin,
    input  logic [7:0] rcon,
    output aes_blk_t   kout
);

    logic [31:0] rot_s;
    logic [31:0] tmp_s;
    logic [31:0] k0_s;
    logic [31:0] k1_s;
    logic [31:0] k2_s;
    logic [31:0] k3_s;

    // RotWord/SubWord/Rcon on word 3, then the chained XOR across words 0..3.
    always_comb begin
        rot_s = {kin[23:0], kin[31:24]};
        tmp_s = {sbox(rot_s[31:24]), sbox(rot_s[23:16]),
                 sbox(rot_s[15:8]),  sbox(rot_s[7:0])} ^ {rcon, 24'h000000};
        k0_s  = kin[127:96] ^ tmp_s;
        k1_s  = kin[95:64]  ^ k0_s;
        k2_s  = kin[63:32]  ^ k1_s;
        k3_s  = kin[31:0]   ^ k2_s;
        kout  = {k0_s, k1_s, k2_s, k3_s};
    end

endmodule

// File: rtl/ece571f23_g5_aes_iter_ctrl.sv
// ---------------------------------------------------------------------------
// ece571f23_g5_aes_iter_ctrl
// Iterative AES-128 encryption sequencer: one round per clock, round keys
// expanded on the fly, ciphertext held until the consumer takes it.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   bus   : valid/ready input (plaintext, key) and output (cipher) channels
//   busy  : high whenever a block is in flight or waiting to be taken
//   round : current round index 0..NR, saturating at NR in DONE
// Parameters: NR (must be 10), ZEROIZE (clear state/key on output handshake).
// ---------------------------------------------------------------------------
module ece571f23_g5_aes_iter_ctrl
    import ece571f23_g5_aes_pkg::*;
#(
    parameter int NR      = NR_AES128,
    parameter bit ZEROIZE = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    ece571f23_g5_aes_iter_ctrl_if.slave    bus,
    output logic                           busy,
    output logic [3:0]                     round
);

    generate
        if (NR != NR_AES128) begin : g_bad_nr
            $error("ece571f23_g5_aes_iter_ctrl: only NR=10 (AES-128) is supported");
        end
    endgenerate

    localparam logic [3:0] NR_L = 4'(NR);

    fsm_e       fsm_r;
    fsm_e       fsm_nxt_s;
    logic [3:0] round_r;
    logic [3:0] round_nxt_s;
    aes_blk_t   state_r;
    aes_blk_t   state_nxt_s;
    aes_blk_t   kreg_r;
    aes_blk_t   kreg_nxt_s;

    aes_blk_t   rk_s;
    aes_blk_t   sb_s;
    aes_blk_t   sr_s;
    aes_blk_t   mc_s;
    aes_blk_t   rnd_s;
    logic [7:0] rcon_s;
    logic       in_ready_s;
    logic       out_valid_s;

    assign rcon_s = rcon_of(round_r);

    ece571f23_g5_aes_key_step u_key_step (
        .kin  (kreg_r),
        .rcon (rcon_s),
        .kout (rk_s)
    );

    // Round function; the final round omits MixColumns.
    always_comb begin
        sb_s = sub_bytes(state_r);
        sr_s = shift_rows(sb_s);
        mc_s = mix_columns(sr_s);
        if (round_r == NR_L) begin
            rnd_s = sr_s ^ rk_s;
        end else begin
            rnd_s = mc_s ^ rk_s;
        end
    end

    // in_ready is gated by rst so it reads 0 during reset, not just after.
    assign in_ready_s    = (fsm_r == IDLE) && !rst;
    assign out_valid_s   = (fsm_r == DONE);
    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.cipher    = out_valid_s ? state_r : '0;
    assign busy          = (fsm_r != IDLE);
    assign round         = round_r;

    // Next-state and datapath update for the sequencer.
    always_comb begin
        fsm_nxt_s   = fsm_r;
        round_nxt_s = round_r;
        state_nxt_s = state_r;
        kreg_nxt_s  = kreg_r;
        case (fsm_r)
            IDLE: begin
                if (bus.in_valid && in_ready_s) begin
                    state_nxt_s = bus.plaintext ^ bus.key;
                    kreg_nxt_s  = bus.key;
                    round_nxt_s = 4'd1;
                    fsm_nxt_s   = ROUND;
                end else begin
                    fsm_nxt_s   = IDLE;
                end
            end
            ROUND: begin
                state_nxt_s = rnd_s;
                kreg_nxt_s  = rk_s;
                if (round_r == NR_L) begin
                    fsm_nxt_s   = DONE;
                end else begin
                    round_nxt_s = round_r + 4'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    fsm_nxt_s   = IDLE;
                    round_nxt_s = 4'd0;
                    if (ZEROIZE) begin
                        state_nxt_s = '0;
                        kreg_nxt_s  = '0;
                    end else begin
                        state_nxt_s = state_r;
                        kreg_nxt_s  = kreg_r;
                    end
                end else begin
                    fsm_nxt_s   = DONE;
                end
            end
            default: begin
                fsm_nxt_s   = IDLE;
                round_nxt_s = 4'd0;
                state_nxt_s = '0;
                kreg_nxt_s  = '0;
            end
        endcase
    end

    // State, round counter and data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r   <= IDLE;
            round_r <= 4'd0;
            state_r <= '0;
            kreg_r  <= '0;
        end else begin
            fsm_r   <= fsm_nxt_s;
            round_r <= round_nxt_s;
            state_r <= state_nxt_s;
            kreg_r  <= kreg_nxt_s;
        end
    end

endmodule

// File: tb/tb_ece571f23_g5_aes_iter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ece571f23_g5_aes_iter_ctrl
// Self-checking bench: known-answer table, hand-written multi-cycle sequences
// (back-pressure, busy ignore, reset mid-operation, back-to-back) and a random
// phase, all checked every cycle against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_ece571f23_g5_aes_iter_ctrl;

    typedef struct packed {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
        logic         chk_r1;
        logic [127:0] r1;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [3:0] round;

    ece571f23_g5_aes_iter_ctrl_if bus();

    ece571f23_g5_aes_iter_ctrl #(.NR(10), .ZEROIZE(1'b1)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .busy  (busy),
        .round (round)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    // Reference model state: a block is pending from its accept cycle until
    // its output handshake; its result is visible 10 edges after acceptance.
    bit           pending = 1'b0;
    int           cyc     = 0;
    int           acc_cyc = 0;
    logic [127:0] m_ct    = '0;
    bit           acc_ev  = 1'b0;
    int           acc_at  = 0;
    bit           out_ev  = 1'b0;
    logic [127:0] out_ct  = '0;

    logic [7:0] ex [256];
    int         lg [256];
    logic [7:0] sb [256];
    vec_t       tbl [3];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return ex[(lg[a] + lg[b]) % 255];
    endfunction

    // Exp/log tables over generator 3, then the S-box from inverse + affine.
    task automatic init_tables();
        logic [7:0] x;
        logic [7:0] inv;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            ex[i] = x;
            lg[x] = i;
            x = x ^ xt(x);
        end
        ex[255] = 8'h01;
        lg[0]   = 0;
        for (int b = 0; b < 256; b++) begin
            inv = (b == 0) ? 8'h00 : ex[(255 - lg[b]) % 255];
            sb[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   st [4][4];
        logic [7:0]   tmp [4][4];
        logic [7:0]   a [4];
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = pt[127 - 8*(4*c + r) -: 8] ^ w[c][31 - 8*r -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    tmp[r][c] = sb[st[r][(c + r) % 4]];
            st = tmp;
            if (rd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = st[r][c];
                    for (int r = 0; r < 4; r++)
                        st[r][c] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r + 1) % 4])
                                 ^ a[(r + 2) % 4] ^ a[(r + 3) % 4];
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    st[r][c] = st[r][c] ^ w[4*rd + c][31 - 8*r -: 8];
        end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127 - 8*(4*c + r) -: 8] = st[r][c];
        return res;
    endfunction

    // One clock: predict handshakes from the model, advance, compare all outputs.
    task automatic tick();
        bit           hs_in;
        bit           hs_out;
        bit           e_ov;
        int           age;
        logic [127:0] pt_c;
        logic [127:0] key_c;
        hs_in  = !pending && !rst && bus.in_valid;
        hs_out = pending && (cyc - acc_cyc >= 10) && !rst && bus.out_ready;
        pt_c   = bus.plaintext;
        key_c  = bus.key;
        out_ct = bus.cipher;
        acc_ev = hs_in;
        out_ev = hs_out;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            pending = 1'b0;
        end else begin
            if (hs_out) pending = 1'b0;
            if (hs_in) begin
                pending = 1'b1;
                acc_cyc = cyc;
                acc_at  = cyc;
                m_ct    = aes_ref(pt_c, key_c);
            end
        end
        age  = cyc - acc_cyc;
        e_ov = pending && (age >= 10);
        check("in_ready",  128'(bus.in_ready),  128'(!pending && !rst));
        check("out_valid", 128'(bus.out_valid), 128'(e_ov));
        check("cipher",    bus.cipher,          e_ov ? m_ct : 128'h0);
        check("busy",      128'(busy),          128'(pending));
        check("round",     128'(round),         pending ? 128'((age + 1 > 10) ? 10 : age + 1) : 128'h0);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offer a vector, check latency/result, optionally stall the consumer.
    task automatic run_block(input vec_t v, input int hold, input string nm);
        int n;
        int lat;
        bus.plaintext = v.pt;
        bus.key       = v.key;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc_ev && n < 20);
        check({nm, "_accepted"}, 128'(acc_ev), 128'h1);
        bus.in_valid  = 1'b0;
        bus.plaintext = rand128();
        bus.key       = rand128();
        lat = 0;
        while (!bus.out_valid && lat < 30) begin
            tick();
            lat++;
            if (lat == 1 && v.chk_r1) check({nm, "_round1_state"}, dut.state_r, v.r1);
        end
        check({nm, "_latency"}, 128'(lat), 128'd10);
        check({nm, "_cipher"}, bus.cipher, v.ct);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({nm, "_hold_cipher"}, bus.cipher, v.ct);
            check({nm, "_hold_in_ready"}, 128'(bus.in_ready), 128'h0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({nm, "_release_ov"}, 128'(bus.out_valid), 128'h0);
        check({nm, "_release_ct"}, bus.cipher, 128'h0);
        check({nm, "_release_ir"}, 128'(bus.in_ready), 128'h1);
    endtask

    // Keep in_valid high across two vectors with out_ready tied high.
    task automatic back_to_back(input vec_t a, input vec_t b, input string nm);
        int           acc_t [2];
        logic [127:0] outs [2];
        int           acc_n;
        int           out_n;
        int           k;
        acc_t = '{0, 0};
        outs  = '{128'h0, 128'h0};
        acc_n = 0;
        out_n = 0;
        k     = 0;
        bus.plaintext = a.pt;
        bus.key       = a.key;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        while ((acc_n < 2 || out_n < 2) && k < 80) begin
            tick();
            k++;
            if (acc_ev && acc_n < 2) begin
                acc_t[acc_n] = acc_at;
                acc_n++;
                if (acc_n == 1) begin
                    bus.plaintext = b.pt;
                    bus.key       = b.key;
                end else begin
                    bus.in_valid  = 1'b0;
                end
            end
            if (out_ev && out_n < 2) begin
                outs[out_n] = out_ct;
                out_n++;
            end
        end
        bus.out_ready = 1'b0;
        check({nm, "_accepts"}, 128'(acc_n), 128'd2);
        check({nm, "_outputs"}, 128'(out_n), 128'd2);
        check({nm, "_gap"}, 128'(acc_t[1] - acc_t[0]), 128'd12);
        check({nm, "_first_ct"}, outs[0], a.ct);
        check({nm, "_second_ct"}, outs[1], b.ct);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit seen_ov;
        init_tables();
        tbl[0] = '{pt: 128'h00112233445566778899aabbccddeeff, key: 128'h000102030405060708090a0b0c0d0e0f,
                   ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, chk_r1: 1'b0, r1: 128'h0};
        tbl[1] = '{pt: 128'h3243f6a8885a308d313198a2e0370734, key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                   ct: 128'h3925841d02dc09fbdc118597196a0b32, chk_r1: 1'b1,
                   r1: 128'ha49c7ff2689f352b6b5bea43026a5049};
        tbl[2] = '{pt: 128'h0, key: 128'h0,
                   ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, chk_r1: 1'b0, r1: 128'h0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.plaintext = '0;
        bus.key       = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        for (int t = 0; t < 3; t++) run_block(tbl[t], 0, $sformatf("kat%0d", t));

        run_block(tbl[0], 20, "backpressure");

        back_to_back(tbl[0], tbl[1], "busy_ignore");
        back_to_back(tbl[1], tbl[2], "b2b");

        // Reset in the middle of round 5: result discarded, no late out_valid.
        bus.plaintext = tbl[0].pt;
        bus.key       = tbl[0].key;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        k = 0;
        while (round != 4'd5 && k < 20) begin
            tick();
            k++;
        end
        check("rst_reach_round5", 128'(round), 128'd5);
        rst = 1'b1;
        tick();
        check("rst_out_valid", 128'(bus.out_valid), 128'h0);
        check("rst_cipher",    bus.cipher,          128'h0);
        check("rst_busy",      128'(busy),          128'h0);
        check("rst_round",     128'(round),         128'h0);
        check("rst_in_ready",  128'(bus.in_ready),  128'h0);
        rst = 1'b0;
        seen_ov = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            seen_ov = seen_ov | bus.out_valid;
        end
        check("rst_no_out_valid", 128'(seen_ov), 128'h0);
        run_block(tbl[1], 0, "after_rst");

        // Random traffic against the model, with occasional reset pulses.
        for (int i = 0; i < 800; i++) begin
            bus.in_valid  = ($urandom_range(0, 1) == 1);
            bus.out_ready = ($urandom_range(0, 2) == 0);
            bus.plaintext = rand128();
            bus.key       = rand128();
            rst           = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
